// File: rtl/uart_rx_ctrl_if.sv
// Consumer-side handshake for uart_rx_ctrl: head-of-FIFO data with valid/ready.
// The receiver drives data/valid through the master modport, the consumer
// answers with ready through the slave modport.
interface uart_rx_ctrl_if;
    logic [3:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready
    );
endinterface

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: receive controller for the 4-bit even-parity UART link.
// Synchronizes the raw line, samples each bit at mid-bit, checks start,
// parity and stop, and buffers good frames in a small FIFO that drains
// through a valid/ready handshake. Error events come out as one-cycle pulses.
// Optional feature: define UART_RX_ERRCNT_EN to build the saturating error
// counter; otherwise err_count is tied to zero.
module uart_rx_ctrl #(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  rx,
    uart_rx_ctrl_if.master        bus,
    output logic                  parity_err,
    output logic                  frame_err,
    output logic                  overflow,
    output logic                  busy,
    output logic [7:0]            err_count
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int PW    = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_MID  = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_BREAK,
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q, state_d;
    logic             rx_meta_q, rxs_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       bit_idx_q, bit_idx_d;
    logic [3:0]       shift_q, shift_d;
    logic             par_ok_q, par_ok_d;
    logic             parity_err_q, parity_err_d;
    logic             frame_err_q, frame_err_d;
    logic             overflow_q, overflow_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [3:0]       mem_q [FIFO_DEPTH];
    logic [3:0]       mem_d [FIFO_DEPTH];
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_valid;

    assign fifo_valid = (wr_ptr_q != rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                        (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign pop        = fifo_valid & bus.rx_ready;

    assign bus.rx_valid = fifo_valid;
    assign bus.rx_data  = fifo_valid ? mem_q[rd_ptr_q[PTR_W-1:0]] : 4'h0;
    assign parity_err   = parity_err_q;
    assign frame_err    = frame_err_q;
    assign overflow     = overflow_q;
    assign busy         = (state_q == S_START) || (state_q == S_DATA) ||
                          (state_q == S_PARITY) || (state_q == S_STOP);

    // Frame sequencer: walks start/data/parity/stop and decides the fate of each frame at mid-stop.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        bit_idx_d    = bit_idx_q;
        shift_d      = shift_q;
        par_ok_d     = par_ok_q;
        parity_err_d = 1'b0;
        frame_err_d  = 1'b0;
        overflow_d   = 1'b0;
        push         = 1'b0;
        case (state_q)
            S_BREAK: begin
                cnt_d = '0;
                if (rxs_q) state_d = S_IDLE;
            end
            S_IDLE: begin
                cnt_d = '0;
                if (!rxs_q) state_d = S_START;
            end
            S_START: begin
                if (cnt_q == CNT_MID) begin
                    cnt_d     = '0;
                    bit_idx_d = 2'd0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d     = '0;
                    shift_d   = {rxs_q, shift_q[3:1]};
                    bit_idx_d = bit_idx_q + 2'd1;
                    if (bit_idx_q == 2'd3) state_d = S_PARITY;
                end
            end
            S_PARITY: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d    = '0;
                    par_ok_d = ~(^shift_q ^ rxs_q);
                    state_d  = S_STOP;
                end
            end
            S_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rxs_q) begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end else if (!par_ok_q) begin
                        parity_err_d = 1'b1;
                        state_d      = S_IDLE;
                    end else if (fifo_full && !pop) begin
                        overflow_d = 1'b1;
                        state_d    = S_IDLE;
                    end else begin
                        push    = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = S_BREAK;
            end
        endcase
    end

    // FIFO bookkeeping: write at the tail on push, advance the head on pop; pointers wrap naturally.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
        if (push) mem_d[wr_ptr_q[PTR_W-1:0]] = shift_q;
    end

    // State, synchronizer and FIFO registers; reset drops any frame in flight.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_meta_q    <= 1'b1;
            rxs_q        <= 1'b1;
            state_q      <= S_BREAK;
            cnt_q        <= '0;
            bit_idx_q    <= 2'd0;
            shift_q      <= 4'h0;
            par_ok_q     <= 1'b0;
            parity_err_q <= 1'b0;
            frame_err_q  <= 1'b0;
            overflow_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            mem_q        <= '{default: 4'h0};
        end else begin
            rx_meta_q    <= rx;
            rxs_q        <= rx_meta_q;
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_idx_q    <= bit_idx_d;
            shift_q      <= shift_d;
            par_ok_q     <= par_ok_d;
            parity_err_q <= parity_err_d;
            frame_err_q  <= frame_err_d;
            overflow_q   <= overflow_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            mem_q        <= mem_d;
        end
    end

`ifdef UART_RX_ERRCNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    // Count every error pulse, sticking at 255 until the next reset.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if ((parity_err_q || frame_err_q || overflow_q) && (err_cnt_q != 8'hFF))
            err_cnt_d = err_cnt_q + 8'd1;
    end

    // Error counter register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= 8'h00;
        else          err_cnt_q <= err_cnt_d;
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = 8'h00;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: table of single frames, hand sequences for the
// timing/glitch/break/overflow/reset corners, and a randomized run checked
// against a queue-based model of the receive FIFO.
module tb_uart_rx_ctrl;
    localparam int N     = 16;
    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       rx = 1'b1;
    logic       parity_err, frame_err, overflow, busy;
    logic [7:0] err_count;

    uart_rx_ctrl_if u_if ();

    uart_rx_ctrl #(.CLKS_PER_BIT(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .bus        (u_if),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .busy       (busy),
        .err_count  (err_count)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int perr_seen = 0, ferr_seen = 0, ovf_seen = 0, stretch_seen = 0;
    logic pe_prev = 1'b0, fe_prev = 1'b0, ov_prev = 1'b0;
    int err_model = 0;
    logic [3:0] q[$];

    typedef struct {
        logic [3:0] data;
        logic       bad_par;
        logic       bad_stop;
        logic       exp_perr;
        logic       exp_ferr;
        logic       exp_valid;
    } vec_t;

    // Count error pulses and flag any that last longer than one cycle.
    always @(negedge clk) begin
        if (parity_err) perr_seen <= perr_seen + 1;
        if (frame_err)  ferr_seen <= ferr_seen + 1;
        if (overflow)   ovf_seen  <= ovf_seen + 1;
        if ((parity_err && pe_prev) || (frame_err && fe_prev) || (overflow && ov_prev))
            stretch_seen <= stretch_seen + 1;
        pe_prev <= parity_err;
        fe_prev <= frame_err;
        ov_prev <= overflow;
    end

    task automatic checkOutput(input string name, input int actual, input int expected);
        total++;
        if (actual != expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    function automatic int expErrCount();
`ifdef UART_RX_ERRCNT_EN
        return (err_model > 255) ? 255 : err_model;
`else
        return 0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic driveBit(input logic v, input int cycles);
        rx = v;
        idle(cycles);
    endtask

    // One full frame: start, data LSB first, parity, stop, then idle-high gap.
    task automatic applyStimulus(input logic [3:0] data, input logic bad_par,
                                 input logic bad_stop, input int gap);
        logic [6:0] bits;
        bits = {~bad_stop, (^data) ^ bad_par, data, 1'b0};
        for (int b = 0; b < 7; b++) driveBit(bits[b], N);
        driveBit(1'b1, gap);
    endtask

    // Reference outcome of a frame when nothing pops during it.
    task automatic modelFrame(input logic [3:0] data, input logic bad_par, input logic bad_stop,
                              output int ep, output int ef, output int eo);
        ep = 0; ef = 0; eo = 0;
        if (bad_stop)               ef = 1;
        else if (bad_par)           ep = 1;
        else if (q.size() == DEPTH) eo = 1;
        else                        q.push_back(data);
        err_model += ep + ef + eo;
    endtask

    task automatic runFrame(input string name, input logic [3:0] data, input logic bad_par,
                            input logic bad_stop, input int gap);
        int p0, f0, o0, ep, ef, eo;
        p0 = perr_seen; f0 = ferr_seen; o0 = ovf_seen;
        applyStimulus(data, bad_par, bad_stop, gap);
        modelFrame(data, bad_par, bad_stop, ep, ef, eo);
        checkOutput($sformatf("%s parity_err", name), perr_seen - p0, ep);
        checkOutput($sformatf("%s frame_err", name), ferr_seen - f0, ef);
        checkOutput($sformatf("%s overflow", name), ovf_seen - o0, eo);
    endtask

    task automatic popCheck(input string name, input logic [3:0] exp_data);
        checkOutput($sformatf("%s rx_valid", name), int'(u_if.rx_valid), 1);
        checkOutput($sformatf("%s rx_data", name), int'(u_if.rx_data), int'(exp_data));
        u_if.rx_ready = 1'b1;
        idle(1);
        u_if.rx_ready = 1'b0;
    endtask

    task automatic drainAll(input string name);
        while (q.size() > 0) popCheck(name, q.pop_front());
        checkOutput($sformatf("%s empty", name), int'(u_if.rx_valid), 0);
    endtask

    vec_t vecs[7];

    initial begin
        vecs[0] = '{4'hB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[1] = '{4'h1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{4'h6, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[3] = '{4'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{4'h5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{4'h9, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        u_if.rx_ready = 1'b0;

        // Reset state
        #12;
        checkOutput("reset rx_valid", int'(u_if.rx_valid), 0);
        checkOutput("reset rx_data", int'(u_if.rx_data), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset pulses", int'(parity_err | frame_err | overflow), 0);
        checkOutput("reset err_count", int'(err_count), 0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(4);

        // Good frame 0xB: rx_valid rises exactly t0+105 (107 edges after the line falls)
        fork
            applyStimulus(4'hB, 1'b0, 1'b0, 4);
            begin
                repeat (106) @(posedge clk);
                @(negedge clk);
                checkOutput("timing valid early", int'(u_if.rx_valid), 0);
                @(posedge clk);
                @(negedge clk);
                checkOutput("timing valid", int'(u_if.rx_valid), 1);
                checkOutput("timing data", int'(u_if.rx_data), 11);
            end
        join
        popCheck("timing pop", 4'hB);
        checkOutput("timing popped", int'(u_if.rx_valid), 0);

        // Table-driven single frames
        for (int i = 0; i < 7; i++) begin
            int p0, f0, o0;
            p0 = perr_seen; f0 = ferr_seen; o0 = ovf_seen;
            applyStimulus(vecs[i].data, vecs[i].bad_par, vecs[i].bad_stop, 4);
            err_model += int'(vecs[i].exp_perr) + int'(vecs[i].exp_ferr);
            checkOutput($sformatf("vec%0d parity_err", i), perr_seen - p0, int'(vecs[i].exp_perr));
            checkOutput($sformatf("vec%0d frame_err", i), ferr_seen - f0, int'(vecs[i].exp_ferr));
            checkOutput($sformatf("vec%0d overflow", i), ovf_seen - o0, 0);
            checkOutput($sformatf("vec%0d err_count", i), int'(err_count), expErrCount());
            checkOutput($sformatf("vec%0d rx_valid", i), int'(u_if.rx_valid), int'(vecs[i].exp_valid));
            if (vecs[i].exp_valid) popCheck($sformatf("vec%0d pop", i), vecs[i].data);
        end

        // Glitch: 3 low cycles is a false start
        begin
            int p0, f0, o0;
            p0 = perr_seen; f0 = ferr_seen; o0 = ovf_seen;
            driveBit(1'b0, 3);
            checkOutput("glitch busy high", int'(busy), 1);
            driveBit(1'b1, N / 2 + 1 + 3);
            checkOutput("glitch busy low", int'(busy), 0);
            checkOutput("glitch pulses", (perr_seen - p0) + (ferr_seen - f0) + (ovf_seen - o0), 0);
            checkOutput("glitch rx_valid", int'(u_if.rx_valid), 0);
        end

        // Frame error then line held low: stays in break until the line returns high
        begin
            int f0;
            logic [6:0] bits;
            f0 = ferr_seen;
            bits = {1'b0, ^4'h3, 4'h3, 1'b0};
            for (int b = 0; b < 7; b++) driveBit(bits[b], N);
            for (int k = 0; k < 3; k++) begin
                driveBit(1'b0, N);
                checkOutput($sformatf("break busy %0d", k), int'(busy), 0);
            end
            err_model++;
            checkOutput("break frame_err", ferr_seen - f0, 1);
            driveBit(1'b1, 4);
            checkOutput("break err_count", int'(err_count), expErrCount());
            runFrame("after break", 4'h3, 1'b0, 1'b0, 4);
            drainAll("after break");
        end

        // Overflow: five back-to-back frames with no consumer
        for (int i = 1; i <= 5; i++) runFrame($sformatf("ovf frame%0d", i), 4'(i), 1'b0, 1'b0, 0);
        idle(4);
        drainAll("ovf drain");

        // Full FIFO with a pop on the push edge accepts the fifth frame
        for (int i = 1; i <= 4; i++) runFrame($sformatf("ovfpop frame%0d", i), 4'(i), 1'b0, 1'b0, 0);
        begin
            int o0;
            o0 = ovf_seen;
            fork
                applyStimulus(4'h5, 1'b0, 1'b0, 4);
                begin
                    repeat (106) @(posedge clk);
                    #1;
                    checkOutput("ovfpop head", int'(u_if.rx_data), 1);
                    u_if.rx_ready = 1'b1;
                    @(posedge clk);
                    #1;
                    u_if.rx_ready = 1'b0;
                end
            join
            checkOutput("ovfpop overflow", ovf_seen - o0, 0);
            q.delete();
            q = '{4'h2, 4'h3, 4'h4, 4'h5};
            drainAll("ovfpop drain");
        end

        // Randomized frames against the queue model, with random partial drains
        for (int i = 0; i < 24; i++) begin
            logic [3:0] d;
            logic bp, bs;
            int k;
            d  = 4'($urandom);
            bp = ($urandom_range(3) == 0);
            bs = ($urandom_range(5) == 0);
            runFrame($sformatf("rand%0d", i), d, bp, bs, 2);
            k = $urandom_range(q.size());
            for (int j = 0; j < k; j++) popCheck($sformatf("rand%0d pop", i), q.pop_front());
        end
        idle(2);
        checkOutput("rand err_count", int'(err_count), expErrCount());
        drainAll("rand drain");

        // Reset mid-DATA clears everything at once
        runFrame("prereset", 4'h7, 1'b0, 1'b0, 4);
        fork
            applyStimulus(4'h6, 1'b0, 1'b0, 0);
            begin
                repeat (56) @(posedge clk);
                #3;
                reset_n = 1'b0;
                #1;
                checkOutput("midreset rx_valid", int'(u_if.rx_valid), 0);
                checkOutput("midreset rx_data", int'(u_if.rx_data), 0);
                checkOutput("midreset busy", int'(busy), 0);
                checkOutput("midreset err_count", int'(err_count), 0);
            end
        join
        q.delete();
        err_model = 0;
        idle(2);
        reset_n = 1'b1;
        idle(4);
        runFrame("postreset", 4'hA, 1'b0, 1'b0, 4);
        drainAll("postreset");
        checkOutput("postreset err_count", int'(err_count), 0);

        checkOutput("pulse width", stretch_seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard time limit so the run always ends
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: got running, expected finished");
        $fatal(1, "[TB] time limit reached");
    end
endmodule
